imm_gen_stage: RTL and testbench

Registered, handshaked immediate-generation stage for the RISC-V decode path. It generalises the combinational immediate generator to XLEN = 32 or 64, decodes the instruction format (R/I/S/B/U/J) and flags unsupported opcodes. It carries a sideband tag (typically the PC) and sits between fetch and the decode/issue logic, with valid/ready flow control, a 2-entry skid buffer for a registered `in_ready`, and a pipeline flush.

---
 rtl/imm_gen_stage_if.sv | 27 ++
 rtl/imm_gen_stage.sv | 129 ++++++++++++
 tb/tb_imm_gen_stage.sv | 277 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/imm_gen_stage_if.sv
// Valid/ready bus between fetch and the immediate-generation stage.
// The slave view belongs to the stage; the master view belongs to the producer/consumer side.
interface imm_gen_stage_if #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned TAG_W = 32
) ();
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      in_instr;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [XLEN-1:0]  out_imm;
    logic [2:0]       out_fmt;
    logic [31:0]      out_instr;
    logic [TAG_W-1:0] out_tag;

    modport slave (
        input  in_valid, in_instr, in_tag, out_ready,
        output in_ready, out_valid, out_imm, out_fmt, out_instr, out_tag
    );

    modport master (
        output in_valid, in_instr, in_tag, out_ready,
        input  in_ready, out_valid, out_imm, out_fmt, out_instr, out_tag
    );
endinterface

// File: rtl/imm_gen_stage.sv
// Registered RISC-V immediate generator with format decode, tag passthrough,
// an output register plus one skid entry, and synchronous flush.
module imm_gen_stage #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned TAG_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    imm_gen_stage_if.slave   bus
);
    localparam logic [2:0] FMT_R   = 3'd0;
    localparam logic [2:0] FMT_I   = 3'd1;
    localparam logic [2:0] FMT_S   = 3'd2;
    localparam logic [2:0] FMT_B   = 3'd3;
    localparam logic [2:0] FMT_U   = 3'd4;
    localparam logic [2:0] FMT_J   = 3'd5;
    localparam logic [2:0] FMT_ILL = 3'd7;

    typedef struct packed {
        logic [XLEN-1:0]  imm;
        logic [2:0]       fmt;
        logic [31:0]      instr;
        logic [TAG_W-1:0] tag;
    } entry_t;

    entry_t             or_q, or_d, sk_q, sk_d, dec_entry;
    logic               or_vld_q, or_vld_d, sk_vld_q, sk_vld_d;
    logic signed [31:0] dec_imm;
    logic [2:0]         dec_fmt;
    logic [31:0]        ins;
    logic               accept;

    assign ins = bus.in_instr;

    // Format decode; the 32-bit immediate is sign-extended to XLEN afterwards.
    always_comb begin
        dec_fmt = FMT_ILL;
        dec_imm = '0;
        case (ins[6:0])
            7'b0000011, 7'b0010011, 7'b1100111, 7'b0001111, 7'b1110011: begin
                dec_fmt = FMT_I;
                dec_imm = {{20{ins[31]}}, ins[31:20]};
            end
            7'b0011011: begin
                if (XLEN == 64) begin
                    dec_fmt = FMT_I;
                    dec_imm = {{20{ins[31]}}, ins[31:20]};
                end
            end
            7'b0100011: begin
                dec_fmt = FMT_S;
                dec_imm = {{20{ins[31]}}, ins[31:25], ins[11:7]};
            end
            7'b1100011: begin
                dec_fmt = FMT_B;
                dec_imm = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
            end
            7'b0110111, 7'b0010111: begin
                dec_fmt = FMT_U;
                dec_imm = {ins[31:12], 12'b0};
            end
            7'b1101111: begin
                dec_fmt = FMT_J;
                dec_imm = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
            end
            7'b0110011: dec_fmt = FMT_R;
            7'b0111011: begin
                if (XLEN == 64) dec_fmt = FMT_R;
            end
            default: ;
        endcase
    end

    always_comb begin
        dec_entry.imm   = XLEN'(dec_imm);
        dec_entry.fmt   = dec_fmt;
        dec_entry.instr = ins;
        dec_entry.tag   = bus.in_tag;
    end

    // in_ready looks only at the skid flag, so it never depends on out_ready.
    assign bus.in_ready = !rst && !flush && !sk_vld_q;
    assign accept       = bus.in_valid && bus.in_ready;

    always_comb begin
        or_d     = or_q;
        sk_d     = sk_q;
        or_vld_d = or_vld_q;
        sk_vld_d = sk_vld_q;
        if (flush) begin
            or_vld_d = 1'b0;
            sk_vld_d = 1'b0;
        end else if (!or_vld_q || bus.out_ready) begin
            if (sk_vld_q) begin
                or_d     = sk_q;
                or_vld_d = 1'b1;
                sk_vld_d = accept;
                if (accept) sk_d = dec_entry;
            end else begin
                or_vld_d = accept;
                if (accept) or_d = dec_entry;
            end
        end else if (accept) begin
            sk_d     = dec_entry;
            sk_vld_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            or_q     <= '0;
            sk_q     <= '0;
            or_vld_q <= 1'b0;
            sk_vld_q <= 1'b0;
        end else begin
            or_q     <= or_d;
            sk_q     <= sk_d;
            or_vld_q <= or_vld_d;
            sk_vld_q <= sk_vld_d;
        end
    end

    assign bus.out_valid = or_vld_q;
    assign bus.out_imm   = or_q.imm;
    assign bus.out_fmt   = or_q.fmt;
    assign bus.out_instr = or_q.instr;
    assign bus.out_tag   = or_q.tag;
endmodule

// File: tb/tb_imm_gen_stage.sv
// Scoreboard bench for imm_gen_stage: XLEN=32 and XLEN=64 instances, directed
// vectors with hand-computed immediates, backpressure, flush and reset mid-stream.
module tb_imm_gen_stage;
    logic clk = 1'b0;
    logic rst;
    logic flush;

    always #5 clk = ~clk;

    imm_gen_stage_if #(.XLEN(32), .TAG_W(32)) b32 ();
    imm_gen_stage_if #(.XLEN(64), .TAG_W(32)) b64 ();

    imm_gen_stage #(.XLEN(32), .TAG_W(32)) dut32 (.clk(clk), .rst(rst), .flush(flush), .bus(b32));
    imm_gen_stage #(.XLEN(64), .TAG_W(32)) dut64 (.clk(clk), .rst(rst), .flush(flush), .bus(b64));

    typedef struct {
        logic [63:0] imm;
        logic [2:0]  fmt;
        logic [31:0] instr;
        logic [31:0] tag;
        int          cyc;
    } exp_t;

    exp_t q32[$];
    exp_t q64[$];
    int   errors = 0;
    int   checks = 0;
    int   cyc    = 0;
    int   n_out32 = 0;
    int   n_out64 = 0;
    bit   lat_chk = 1'b0;

    logic [63:0] cur_imm32, cur_imm64;
    logic [2:0]  cur_fmt32, cur_fmt64;

    // XLEN=32 vectors: instruction, expected immediate, expected format
    logic [31:0] t32_instr [10] = '{32'hFFF10067, 32'hFE112E23, 32'hFE000CE3, 32'h123450B7,
                                    32'h001000EF, 32'h002081B3, 32'h0000007F, 32'hFFF0809B,
                                    32'h00500093, 32'h00B5053B};
    logic [63:0] t32_imm   [10] = '{64'hFFFFFFFF, 64'hFFFFFFFC, 64'hFFFFFFF8, 64'h12345000,
                                    64'h00000800, 64'h0, 64'h0, 64'h0, 64'h5, 64'h0};
    logic [2:0]  t32_fmt   [10] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd0, 3'd7, 3'd7, 3'd1, 3'd7};

    logic [31:0] t64_instr [5] = '{32'h800000B7, 32'hFFF0809B, 32'h00B5053B, 32'hFE112E23, 32'h0000007F};
    logic [63:0] t64_imm   [5] = '{64'hFFFFFFFF80000000, 64'hFFFFFFFFFFFFFFFF, 64'h0,
                                   64'hFFFFFFFFFFFFFFFC, 64'h0};
    logic [2:0]  t64_fmt   [5] = '{3'd4, 3'd1, 3'd0, 3'd2, 3'd7};

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive32(input int i, input logic [31:0] tg);
        b32.in_valid = 1'b1;
        b32.in_instr = t32_instr[i];
        b32.in_tag   = tg;
        cur_imm32    = t32_imm[i];
        cur_fmt32    = t32_fmt[i];
    endtask

    task automatic drive64(input int i, input logic [31:0] tg);
        b64.in_valid = 1'b1;
        b64.in_instr = t64_instr[i];
        b64.in_tag   = tg;
        cur_imm64    = t64_imm[i];
        cur_fmt64    = t64_fmt[i];
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard for the XLEN=32 instance: pop on output handshake, push on accept
    always @(negedge clk) begin : sb32
        exp_t e;
        if (b32.out_valid && b32.out_ready && !rst && !flush) begin
            n_out32++;
            if (q32.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb32_unexpected: got tag %h with no entry expected", b32.out_tag);
            end else begin
                e = q32.pop_front();
                chk("sb32_imm",   64'(b32.out_imm),   e.imm);
                chk("sb32_fmt",   64'(b32.out_fmt),   64'(e.fmt));
                chk("sb32_instr", 64'(b32.out_instr), 64'(e.instr));
                chk("sb32_tag",   64'(b32.out_tag),   64'(e.tag));
                if (lat_chk) chk("sb32_latency", 64'(cyc - e.cyc), 64'd1);
            end
        end
        if (rst || flush) q32.delete();
        else if (b32.in_valid && b32.in_ready)
            q32.push_back('{cur_imm32, cur_fmt32, b32.in_instr, b32.in_tag, cyc});
    end

    always @(negedge clk) begin : sb64
        exp_t e;
        if (b64.out_valid && b64.out_ready && !rst && !flush) begin
            n_out64++;
            if (q64.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb64_unexpected: got tag %h with no entry expected", b64.out_tag);
            end else begin
                e = q64.pop_front();
                chk("sb64_imm", b64.out_imm,        e.imm);
                chk("sb64_fmt", 64'(b64.out_fmt),   64'(e.fmt));
                chk("sb64_tag", 64'(b64.out_tag),   64'(e.tag));
            end
        end
        if (rst || flush) q64.delete();
        else if (b64.in_valid && b64.in_ready)
            q64.push_back('{cur_imm64, cur_fmt64, b64.in_instr, b64.in_tag, cyc});
    end

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : main
        int  n_acc;
        bit  acc;
        logic [31:0] tg;

        rst = 1'b1;
        flush = 1'b0;
        b32.in_valid = 1'b0; b32.in_instr = '0; b32.in_tag = '0; b32.out_ready = 1'b1;
        b64.in_valid = 1'b0; b64.in_instr = '0; b64.in_tag = '0; b64.out_ready = 1'b1;
        cur_imm32 = '0; cur_fmt32 = '0; cur_imm64 = '0; cur_fmt64 = '0;

        // Reset state, with an instruction offered that must not be taken
        repeat (2) @(posedge clk);
        #1 drive32(0, 32'hDEAD);
        @(negedge clk);
        chk("rst_in_ready",  64'(b32.in_ready),  64'd0);
        chk("rst_out_valid", 64'(b32.out_valid), 64'd0);
        chk("rst_out_imm",   64'(b32.out_imm),   64'd0);
        chk("rst_out_fmt",   64'(b32.out_fmt),   64'd0);
        chk("rst_out_instr", 64'(b32.out_instr), 64'd0);
        chk("rst_out_tag",   64'(b32.out_tag),   64'd0);
        chk("rst_out_imm64", b64.out_imm,        64'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        b32.in_valid = 1'b0;
        @(negedge clk);
        chk("post_rst_in_ready",  64'(b32.in_ready),  64'd1);
        chk("post_rst_out_valid", 64'(b32.out_valid), 64'd0);

        // Back-to-back streaming of all XLEN=32 format vectors
        lat_chk = 1'b1;
        n_out32 = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1 drive32(i, 32'h1000 + 32'(i));
        end
        @(posedge clk);
        #1 b32.in_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("stream_count", 64'(n_out32), 64'd10);
        lat_chk = 1'b0;

        // Backpressure: 4 stalled cycles, exactly two accepts
        @(posedge clk);
        #1 b32.out_ready = 1'b0;
        tg = 32'h2000;
        drive32(2, tg);
        n_acc = 0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            acc = b32.in_ready;
            if (k >= 2) chk("bp_in_ready_low", 64'(b32.in_ready), 64'd0);
            if (k >= 1) begin
                chk("bp_out_valid_hold", 64'(b32.out_valid), 64'd1);
                chk("bp_out_tag_hold",   64'(b32.out_tag),   64'h2000);
            end
            @(posedge clk);
            #1;
            if (acc) begin
                n_acc++;
                tg = tg + 32'd1;
                drive32(2 + n_acc, tg);
            end
        end
        chk("bp_accepts", 64'(n_acc), 64'd2);
        b32.out_ready = 1'b1;
        @(negedge clk);
        chk("rel_in_ready_first", 64'(b32.in_ready), 64'd0);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("rel_in_ready_next", 64'(b32.in_ready), 64'd1);
        @(posedge clk);
        #1 b32.in_valid = 1'b0;
        repeat (3) @(posedge clk);

        // Flush while OR and SK both hold entries
        #1 b32.out_ready = 1'b0;
        drive32(5, 32'h3000);
        @(posedge clk);
        #1 drive32(6, 32'h3001);
        @(posedge clk);
        #1 drive32(0, 32'h3002);
        flush = 1'b1;
        @(negedge clk);
        chk("flush_in_ready", 64'(b32.in_ready), 64'd0);
        @(posedge clk);
        #1 flush = 1'b0;
        b32.in_valid = 1'b0;
        b32.out_ready = 1'b1;
        @(negedge clk);
        chk("flush_out_valid", 64'(b32.out_valid), 64'd0);
        chk("flush_in_ready_after", 64'(b32.in_ready), 64'd1);

        // Flush with an instruction offered into an empty stage
        @(posedge clk);
        #1 drive32(1, 32'h3003);
        flush = 1'b1;
        @(negedge clk);
        chk("flush_in_ready_empty", 64'(b32.in_ready), 64'd0);
        @(posedge clk);
        #1 flush = 1'b0;
        b32.in_valid = 1'b0;
        @(negedge clk);
        chk("flush_no_accept", 64'(b32.out_valid), 64'd0);

        // Reset mid-stream, then restart
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1 drive32(i, 32'h4000 + 32'(i));
        end
        @(posedge clk);
        #1 rst = 1'b1;
        drive32(4, 32'h4004);
        @(negedge clk);
        chk("mid_rst_in_ready", 64'(b32.in_ready), 64'd0);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("mid_rst_out_valid", 64'(b32.out_valid), 64'd0);
        chk("mid_rst_out_imm",   64'(b32.out_imm),   64'd0);
        chk("mid_rst_out_fmt",   64'(b32.out_fmt),   64'd0);
        chk("mid_rst_out_instr", 64'(b32.out_instr), 64'd0);
        chk("mid_rst_out_tag",   64'(b32.out_tag),   64'd0);
        chk("mid_rst_in_ready2", 64'(b32.in_ready),  64'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        drive32(3, 32'h5000);
        @(negedge clk);
        chk("restart_in_ready", 64'(b32.in_ready), 64'd1);
        @(posedge clk);
        #1 b32.in_valid = 1'b0;
        @(negedge clk);
        chk("restart_out_valid", 64'(b32.out_valid), 64'd1);
        chk("restart_out_tag",   64'(b32.out_tag),   64'h5000);
        repeat (2) @(posedge clk);

        // XLEN=64 vectors, streamed
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1 drive64(i, 32'h6000 + 32'(i));
        end
        @(posedge clk);
        #1 b64.in_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("x64_count", 64'(n_out64), 64'd5);

        chk("q32_drained", 64'(q32.size()), 64'd0);
        chk("q64_drained", 64'(q64.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
